// File: rtl/jk_updown_counter_pkg.sv
// ----------------------------------------------------------------------------
// counter_pkg
//   Shared definitions for the JK-cell up/down counter.
//   - Direction encoding for the UP input (DIR_UP / DIR_DN).
//   - Excitation-mode enum used to select how J/K are derived.
//   - Helpers that turn WIDTH/MODULUS into the terminal value and range check.
//   No ports (package).
// ----------------------------------------------------------------------------
package counter_pkg;

   // Direction encoding seen on the UP input
   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // How the per-bit J/K pair is derived for the current cycle
   typedef enum logic [1:0] {
      ExcHold  = 2'd0,  // J = K = 0
      ExcCount = 2'd1,  // J = K = toggle mask
      ExcLoad  = 2'd2   // J = next, K = ~next
   } exc_mode_t;

   // True when MODULUS fits the legal range 2 .. 2**WIDTH
   function automatic bit modulus_ok(input int unsigned width, input int unsigned modulus);
      longint unsigned span;
      if (width == 0 || width > 31) begin
         return 1'b0;
      end
      span = longint'(1) << width;
      return (modulus >= 2) && (longint'(modulus) <= span);
   endfunction

   // Largest count value, MODULUS-1, as a plain integer
   function automatic int unsigned calc_maxval(input int unsigned modulus);
      return modulus - 1;
   endfunction

endpackage : counter_pkg

// File: rtl/jk_updown_counter_cell.sv
// ----------------------------------------------------------------------------
// jk_cell
//   Single JK flip-flop, rising-edge clocked, asynchronous active-high reset.
//   J/K: 00 hold, 01 reset, 10 set, 11 toggle.
// Ports:
//   CLK   in   rising-edge clock
//   RST   in   asynchronous reset, active-high (Q=0, QBAR=1)
//   J     in   set excitation
//   K     in   reset excitation
//   Q     out  stored bit
//   QBAR  out  complement of stored bit
// ----------------------------------------------------------------------------
module jk_cell (
   input  logic CLK,
   input  logic RST,
   input  logic J,
   input  logic K,
   output logic Q,
   output logic QBAR
);

   logic state;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= 1'b0;
      end else begin
         case ({J, K})
            2'b01:   state <= 1'b0;
            2'b10:   state <= 1'b1;
            2'b11:   state <= ~state;
            default: state <= state;
         endcase
      end
   end

   assign Q    = state;
   assign QBAR = ~state;

endmodule : jk_cell

// File: rtl/jk_updown_counter.sv
// ----------------------------------------------------------------------------
// jk_updown_counter
//   Synchronous modulo-MODULUS up/down counter whose state bits are JK cells.
//   The next count is computed combinationally, then converted into per-bit
//   J/K excitation. Priority at each edge: RST > LOAD > EN > hold.
// Parameters:
//   WIDTH    number of state bits / JK cells
//   MODULUS  count range 0 .. MODULUS-1, legal 2 .. 2**WIDTH
// Ports:
//   CLK   in   rising-edge clock
//   RST   in   asynchronous reset, active-high
//   EN    in   count enable
//   UP    in   direction, 1 = increment, 0 = decrement
//   LOAD  in   synchronous parallel load (overrides EN)
//   DIN   in   parallel load value, clamped to MODULUS-1
//   Q     out  current count (JK cell Q outputs)
//   QBAR  out  complement of Q (JK cell QBAR outputs)
//   TC    out  terminal count, combinational; high in the cycle whose edge wraps
// ----------------------------------------------------------------------------
module jk_updown_counter
   import counter_pkg::*;
#(
   parameter int unsigned WIDTH   = 4,
   parameter int unsigned MODULUS = 10
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             UP,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] DIN,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] QBAR,
   output logic             TC
);

   // Elaboration-time range check on MODULUS
   if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("jk_updown_counter: MODULUS must lie in 2 .. 2**WIDTH");
   end

   localparam logic [WIDTH-1:0] MAXVAL = WIDTH'(calc_maxval(MODULUS));
   localparam logic [WIDTH-1:0] ZERO   = '0;

   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic [WIDTH-1:0] next;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   exc_mode_t        mode;

   // Next-state selection
   always_comb begin
      next = q;
      mode = ExcHold;
      if (LOAD) begin
         mode = ExcLoad;
         // Comparing against MAXVAL also covers MODULUS == 2**WIDTH, where
         // no DIN can exceed it and the clamp never fires.
         next = (DIN > MAXVAL) ? MAXVAL : DIN;
      end else if (EN) begin
         mode = ExcCount;
         if (UP == DIR_UP) begin
            // ">=" sends an out-of-range state straight to 0
            next = (q >= MAXVAL) ? ZERO : q + WIDTH'(1);
         end else begin
            if (q == ZERO || q > MAXVAL) begin
               next = MAXVAL;
            end else begin
               next = q - WIDTH'(1);
            end
         end
      end
   end

   // Per-bit J/K excitation
   always_comb begin
      j = '0;
      k = '0;
      unique case (mode)
         ExcLoad: begin
            j = next;
            k = ~next;
         end
         ExcCount: begin
            // toggle exactly the bits that differ
            j = q ^ next;
            k = q ^ next;
         end
         default: begin
            j = '0;
            k = '0;
         end
      endcase
   end

   // JK state cells
   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      jk_cell u_cell (
         .CLK  (CLK),
         .RST  (RST),
         .J    (j[i]),
         .K    (k[i]),
         .Q    (q[i]),
         .QBAR (qbar[i])
      );
   end

   assign Q    = q;
   assign QBAR = qbar;

   assign TC = EN & ~LOAD & (((UP == DIR_UP) & (q == MAXVAL)) |
                             ((UP == DIR_DN) & (q == ZERO)));

endmodule : jk_updown_counter

// File: tb/tb_jk_updown_counter.sv
module tb_jk_updown_counter;

   logic       clk;
   logic       rst;
   logic       en, up, load;
   logic [3:0] din;
   logic [3:0] q, qbar;
   logic       tc;

   logic       en16, up16, load16;
   logic [3:0] din16;
   logic [3:0] q16, qbar16;
   logic       tc16;

   int n_vec = 0;
   int n_err = 0;

   jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
      .CLK(clk), .RST(rst), .EN(en), .UP(up), .LOAD(load), .DIN(din),
      .Q(q), .QBAR(qbar), .TC(tc)
   );

   jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
      .CLK(clk), .RST(rst), .EN(en16), .UP(up16), .LOAD(load16), .DIN(din16),
      .Q(q16), .QBAR(qbar16), .TC(tc16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_val(input logic [3:0] v);
      load = 1'b1; din = v; en = 1'b0;
      tick();
      load = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 0; up = 1; load = 0; din = 0;
      en16 = 0; up16 = 1; load16 = 0; din16 = 0;
      #12;
      n_vec++;
      if (q !== 4'd0) begin $display("FAIL reset_q got %0d want 0", q); n_err++; end
      rst = 1'b0;
      tick();
      load_val(4'd7);
      n_vec++;
      if (q !== 4'd7) begin $display("FAIL load7 got %0d want 7", q); n_err++; end
      #3 rst = 1'b1;
      #1;
      n_vec++;
      if (q !== 4'd0 || qbar !== 4'hF) begin
         $display("FAIL async_reset got q=%0d qbar=%h want 0/f", q, qbar); n_err++;
      end
      rst = 1'b0;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if (q !== 4'd0 || tc !== 1'b0) begin
            $display("FAIL hold_after_reset[%0d] got q=%0d tc=%b want 0/0", i, q, tc); n_err++;
         end
      end
   endtask

   task automatic test_up_wrap();
      logic [3:0] exp;
      exp = 4'd0;
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         n_vec++;
         if (tc !== (exp == 4'd9)) begin
            $display("FAIL up_tc[%0d] got %b want %b", i, tc, (exp == 4'd9)); n_err++;
         end
         tick();
         exp = (exp == 4'd9) ? 4'd0 : exp + 4'd1;
         n_vec++;
         if (q !== exp || qbar !== ~exp) begin
            $display("FAIL up_q[%0d] got q=%0d qbar=%h want %0d/%h", i, q, qbar, exp, ~exp);
            n_err++;
         end
      end
      en = 1'b0;
   endtask

   task automatic test_down_wrap();
      logic [3:0] seq [4];
      logic [3:0] cur;
      seq = '{4'd1, 4'd0, 4'd9, 4'd8};
      load_val(4'd2);
      cur = 4'd2;
      en = 1'b1; up = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         n_vec++;
         if (tc !== (cur == 4'd0)) begin
            $display("FAIL dn_tc[%0d] got %b want %b", i, tc, (cur == 4'd0)); n_err++;
         end
         tick();
         n_vec++;
         if (q !== seq[i]) begin
            $display("FAIL dn_q[%0d] got %0d want %0d", i, q, seq[i]); n_err++;
         end
         cur = seq[i];
      end
      en = 1'b0;
   endtask

   task automatic test_load_clamp();
      logic [3:0] dins [4];
      logic [3:0] exps [4];
      dins = '{4'd5, 4'd12, 4'd10, 4'd9};
      exps = '{4'd5, 4'd9, 4'd9, 4'd9};
      load_val(4'd9);
      // Q=9, UP=1, EN=1: TC would be 1 without LOAD
      en = 1'b1; up = 1'b1;
      for (int i = 0; i < 4; i++) begin
         load = 1'b1; din = dins[i];
         #1;
         n_vec++;
         if (tc !== 1'b0) begin $display("FAIL load_tc[%0d] got %b want 0", i, tc); n_err++; end
         tick();
         n_vec++;
         if (q !== exps[i]) begin
            $display("FAIL load_q[%0d] din=%0d got %0d want %0d", i, dins[i], q, exps[i]);
            n_err++;
         end
      end
      load = 1'b0; en = 1'b0;
      // hold in a nonzero state
      tick();
      n_vec++;
      if (q !== 4'd9) begin $display("FAIL hold9 got %0d want 9", q); n_err++; end
   endtask

   task automatic test_dir_change();
      logic       ups  [4];
      logic [3:0] exps [4];
      ups  = '{1'b1, 1'b1, 1'b0, 1'b0};
      exps = '{4'd5, 4'd6, 4'd5, 4'd4};
      load_val(4'd4);
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         up = ups[i];
         tick();
         n_vec++;
         if (q !== exps[i]) begin
            $display("FAIL dir_q[%0d] got %0d want %0d", i, q, exps[i]); n_err++;
         end
      end
      // asynchronous reset pulse between edges
      en = 1'b1; up = 1'b1;
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (q !== 4'd0) begin $display("FAIL rst_pulse got %0d want 0", q); n_err++; end
      rst = 1'b0;
      tick();
      n_vec++;
      if (q !== 4'd1) begin $display("FAIL after_rst_q got %0d want 1", q); n_err++; end
      en = 1'b0;
   endtask

   task automatic test_full_range();
      load16 = 1'b1; din16 = 4'd15;
      tick();
      load16 = 1'b0;
      n_vec++;
      if (q16 !== 4'd15) begin $display("FAIL m16_load got %0d want 15", q16); n_err++; end
      en16 = 1'b1; up16 = 1'b1;
      #1;
      n_vec++;
      if (tc16 !== 1'b1) begin $display("FAIL m16_tc_up got %b want 1", tc16); n_err++; end
      tick();
      n_vec++;
      if (q16 !== 4'd0 || qbar16 !== 4'hF) begin
         $display("FAIL m16_wrap got q=%0d qbar=%h want 0/f", q16, qbar16); n_err++;
      end
      up16 = 1'b0;
      #1;
      n_vec++;
      if (tc16 !== 1'b1) begin $display("FAIL m16_tc_dn got %b want 1", tc16); n_err++; end
      tick();
      n_vec++;
      if (q16 !== 4'd15) begin $display("FAIL m16_dn_wrap got %0d want 15", q16); n_err++; end
      en16 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_load_clamp();
      test_dir_change();
      test_full_range();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule : tb_jk_updown_counter
